// File: rtl/sha_mining_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : sha_mining_sequencer
// Sweeps a nonce range through the SHA-256 datapath and reports the first
// nonce whose hash is <= target. Optional macro SEQ_HASH_COUNT_EN enables
// the hash_count counter.
// Revision : 1.0
// ============================================================================
module sha_mining_sequencer #(
    parameter int ROUND_CYCLES = 1,
    parameter int NONCE_MSB    = 511
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic         abort,
    input  logic [31:0]  nonce_init,
    input  logic [31:0]  nonce_limit,
    input  logic [255:0] target,
    input  logic [255:0] hash_in,
    output logic [2:0]   state,
    output logic [8:0]   nonce_width,
    output logic         mem_we,
    output logic [31:0]  mem_wdata,
    output logic         busy,
    output logic         done,
    output logic         found,
    output logic [31:0]  golden_nonce,
    output logic [31:0]  hash_count
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_NONCE  = 3'd2,
        S_CHUNK  = 3'd3,
        S_EXPAND = 3'd4,
        S_ROUNDS = 3'd5,
        S_FINAL  = 3'd6,
        S_CHECK  = 3'd7
    } state_t;

    localparam logic [7:0] ROUND_LAST = 8'(ROUND_CYCLES - 1);

    state_t         r_state;
    state_t         w_next;
    logic [7:0]     r_dwell;
    logic [31:0]    r_cur_nonce;
    logic [31:0]    r_limit;
    logic [255:0]   r_target;
    logic           r_done;
    logic           r_found;
    logic [31:0]    r_golden;
    logic           w_start_ok;
    logic           w_win;
    logic           w_last;

    assign w_win = (hash_in <= r_target);
    assign w_last = (r_cur_nonce == r_limit);

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_start_ok = 1'b0;
        mem_we     = 1'b0;
        if (abort) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        w_start_ok = 1'b1;
                        w_next     = S_LOAD;
                    end
                end
                S_LOAD: begin
                    mem_we = 1'b1;
                    w_next = S_NONCE;
                end
                // Preprocessing needs two clock edges with the nonce presented
                S_NONCE:  if (r_dwell == 8'd1) w_next = S_CHUNK;
                S_CHUNK:  w_next = S_EXPAND;
                S_EXPAND: w_next = S_ROUNDS;
                S_ROUNDS: if (r_dwell == ROUND_LAST) w_next = S_FINAL;
                S_FINAL:  w_next = S_CHECK;
                S_CHECK:  w_next = (w_win || w_last) ? S_IDLE : S_LOAD;
                default:  w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset || abort || (w_next != r_state) || (r_state == S_IDLE)) begin
            r_dwell <= 8'd0;
        end else begin
            r_dwell <= r_dwell + 8'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_cur_nonce <= 32'd0;
            r_limit     <= 32'd0;
            r_target    <= 256'd0;
            r_done      <= 1'b0;
            r_found     <= 1'b0;
            r_golden    <= 32'd0;
        end else begin
            r_done <= 1'b0;
            if (w_start_ok) begin
                r_cur_nonce <= nonce_init;
                r_limit     <= nonce_limit;
                r_target    <= target;
                r_found     <= 1'b0;
                r_golden    <= 32'd0;
            end else if ((r_state == S_CHECK) && !abort) begin
                if (w_win) begin
                    r_found  <= 1'b1;
                    r_golden <= r_cur_nonce;
                    r_done   <= 1'b1;
                end else if (w_last) begin
                    r_done <= 1'b1;
                end else begin
                    r_cur_nonce <= r_cur_nonce + 32'd1;
                end
            end
        end
    end

`ifdef SEQ_HASH_COUNT_EN
    logic [31:0] r_hash_count;

    always_ff @(posedge clock) begin
        if (!reset || w_start_ok) begin
            r_hash_count <= 32'd0;
        end else if ((r_state == S_CHECK) && (r_hash_count != 32'hFFFF_FFFF)) begin
            r_hash_count <= r_hash_count + 32'd1;
        end
    end

    assign hash_count = r_hash_count;
`else
    assign hash_count = 32'd0;
`endif

    assign state        = r_state;
    assign nonce_width  = 9'(NONCE_MSB);
    assign mem_wdata    = r_cur_nonce;
    assign busy         = (r_state != S_IDLE);
    assign done         = r_done;
    assign found        = r_found;
    assign golden_nonce = r_golden;

endmodule
`default_nettype wire

// File: doc/sha_mining_sequencer.md
Name: sha_mining_sequencer

Overview:
Top-level controller for the SHA-256 mining datapath. It drives the shared 3-bit `state` bus seen by the preprocessing and chunk-hashing blocks, and writes the current nonce into the message memory. It sweeps a nonce range, compares each 256-bit hash against a target, and reports the first winning nonce. One sequencer per hashing pipeline; the host reaches it through start/abort/done.

Parameters:
- ROUND_CYCLES, 1: cycles spent in ROUNDS (state 5); range 1..255; lets a future multi-cycle round engine be used without changing the FSM.
- NONCE_MSB, 511: bit index of the nonce MSB in the memory word; passed through on `nonce_width`.

Ports:
- clock, input, 1: rising-edge clock.
- reset, input, 1: synchronous, active-low.
- start, input, 1: one-cycle request to begin a sweep. Sampled only in IDLE.
- abort, input, 1: synchronous stop. Returns to IDLE next cycle.
- nonce_init, input, 32: first nonce tried. Sampled when start is accepted.
- nonce_limit, input, 32: last nonce tried, inclusive. Sampled when start is accepted.
- target, input, 256: a hash wins when `hash_in <= target` (unsigned). Sampled when start is accepted.
- hash_in, input, 256: HASH output of the chunk block.
- state, output, 3: datapath phase bus.
- nonce_width, output, 9: constant NONCE_MSB.
- mem_we, output, 1: memory write strobe for the nonce.
- mem_wdata, output, 32: nonce to write.
- busy, output, 1: high while not in IDLE.
- done, output, 1: one-cycle pulse at the end of a sweep.
- found, output, 1: sticky winning flag; cleared at start.
- golden_nonce, output, 32: winning nonce; valid while found=1.
- hash_count, output, 32: number of hashes attempted (see Optional Feature).

Behaviour:
- **Reset (reset=0 at clock edge):**
  - FSM goes to IDLE.
  - state=0, mem_we=0, mem_wdata=0, busy=0, done=0, found=0, golden_nonce=0, hash_count=0.
  - Internal nonce, limit, target and dwell counter are cleared.
  - Reset mid-sweep abandons the sweep with no done pulse.
- **FSM states** (the `state` output equals the encoding shown):
  - IDLE (0): wait. On start=1 and abort=0:
    - latch cur_nonce=nonce_init, limit, target;
    - clear found and golden_nonce;
    - go to LOAD.
  - LOAD (1): one cycle. mem_we=1 and mem_wdata=cur_nonce; go to NONCE.
  - NONCE (2): exactly 2 cycles, because the preprocessing block needs two edges. Then go to CHUNK.
  - CHUNK (3): 1 cycle, then EXPAND.
  - EXPAND (4): 1 cycle, then ROUNDS.
  - ROUNDS (5): ROUND_CYCLES cycles, counted by the dwell counter. Then FINAL.
  - FINAL (6): 1 cycle, then CHECK.
  - CHECK (7): 1 cycle; hash_in is already registered here. Exit rules:
    - `hash_in <= target`: found=1, golden_nonce=cur_nonce, done pulse, go to IDLE.
    - otherwise, cur_nonce == limit: done pulse with found=0, go to IDLE.
    - otherwise: cur_nonce = cur_nonce + 1 (mod 2^32), go to LOAD.
- **Timing:**
  - Per-nonce cost is 7 + ROUND_CYCLES cycles (8 at default).
  - First mem_we occurs 1 cycle after start is accepted.
  - done is asserted in the cycle following CHECK, together with state=0.
- **Wrap-around:** if nonce_limit < nonce_init, the sweep passes 0xFFFFFFFF → 0x00000000 and stops after testing the limit. If nonce_init == nonce_limit, exactly one hash is attempted.
- **Simultaneous and out-of-phase events:**
  - start while busy is ignored.
  - start and abort together in IDLE: abort wins and the FSM stays in IDLE.
  - abort in any busy state: IDLE next cycle, no done pulse, found and golden_nonce unchanged, the dwell counter clears.
  - Changes on nonce_init, nonce_limit or target during a sweep have no effect.
- **Arithmetic:** all comparisons are unsigned, full width. Dwell counter is 8 bits.

Optional Feature:
- Macro: `SEQ_HASH_COUNT_EN`.
- Defined:
  - hash_count increments by 1 in every CHECK cycle (saturating at 0xFFFFFFFF);
  - clears on reset and on an accepted start;
  - holds its value across abort and IDLE.
- Undefined: hash_count is tied to 0 and the counter logic is absent.

Test Plan:
- Reset then idle: reset=0 for 2 cycles → state=0, busy=0, found=0, done=0, mem_we=0, hash_count=0.
- Single nonce miss: nonce_init = nonce_limit = 0x00000010, target=0, hash_in=0xFF..FF → exactly one mem_we with mem_wdata=0x10. State sequence 1,2,2,3,4,5,6,7,0. done pulses at cycle 9 after start, found=0, hash_count=1.
- Win on third nonce: init=0x100, limit=0x1FF, target=0x0000FFFF..., model returns a hash below target only for nonce 0x102 → done after 3×8 cycles, found=1, golden_nonce=0x102, hash_count=3.
- Wrap-around: init=0xFFFFFFFE, limit=0x00000001, no win → mem_wdata sequence FFFFFFFE, FFFFFFFF, 00000000, 00000001, then done with found=0, hash_count=4.
- Abort mid-ROUNDS with ROUND_CYCLES=4: abort on the 2nd ROUNDS cycle → state=0 next cycle, no done, busy=0. A new start then begins from the new nonce_init.
- Start ignored while busy and start+abort in IDLE: a second start during EXPAND does not restart the sweep (mem_wdata is unchanged). start=abort=1 in IDLE → busy stays 0.
